// File: rtl/wb_port_arbiter.sv
// wb_port_arbiter: register-file write port shared by a single-cycle ALU (A, priority) and a 2-deep FIFO of long-latency results (B).
// Define WB_ARB_STARVE_GUARD_EN to force B to win after STARVE_MAX consecutive lost cycles.
module wb_port_arbiter #(
  parameter int STARVE_MAX = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_en,
  input  logic [4:0]  a_addr,
  input  logic [31:0] a_data,
  output logic        a_stall,
  input  logic        b_valid,
  output logic        b_ready,
  input  logic [4:0]  b_addr,
  input  logic [31:0] b_data,
  output logic        wr_en,
  output logic [4:0]  wr_addr,
  output logic [31:0] wr_data
);
  if (STARVE_MAX < 1 || STARVE_MAX > 7) begin : g_bad_starve_max
    $error("STARVE_MAX must be in 1..7");
  end
  logic [1:0]  cnt_q, cnt_d, cnt_mid;
  logic [36:0] e0_q, e0_d, e1_q, e1_d, e0_mid;
  logic        wr_en_q, wr_en_d, a_stall_q, a_stall_d;
  logic [4:0]  wr_addr_q, wr_addr_d;
  logic [31:0] wr_data_q, wr_data_d;
  logic        a_win, pop, push;
  assign b_ready = cnt_q < 2'd2;
  assign a_stall = a_stall_q;
  assign wr_en   = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  // e0 is always the FIFO head; a push lands in the first slot free after this cycle's pop
  always_comb begin
    a_win     = a_en & ~a_stall_q;
    pop       = ~a_win & (cnt_q != 2'd0);
    push      = b_valid & b_ready;
    cnt_mid   = cnt_q - {1'b0, pop};
    e0_mid    = pop ? e1_q : e0_q;
    e0_d      = (push && cnt_mid == 2'd0) ? {b_addr, b_data} : e0_mid;
    e1_d      = (push && cnt_mid == 2'd1) ? {b_addr, b_data} : e1_q;
    cnt_d     = cnt_mid + {1'b0, push};
    wr_addr_d = a_win ? a_addr : pop ? e0_q[36:32] : wr_addr_q;
    wr_data_d = a_win ? a_data : pop ? e0_q[31:0] : wr_data_q;
    wr_en_d   = (a_win | pop) & (wr_addr_d != 5'd0);
  end
`ifdef WB_ARB_STARVE_GUARD_EN
  logic [2:0] starve_q, starve_d;
  always_comb begin
    starve_d  = (a_win && cnt_q != 2'd0) ? starve_q + 3'd1 : 3'd0;
    a_stall_d = starve_d == 3'(STARVE_MAX);
  end
  always_ff @(posedge clk)
    if (!rst) starve_q <= 3'd0;
    else      starve_q <= starve_d;
`else
  assign a_stall_d = 1'b0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q     <= 2'd0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= 5'd0;
      wr_data_q <= 32'd0;
      a_stall_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      a_stall_q <= a_stall_d;
    end
  end
  always_ff @(posedge clk) begin
    e0_q <= e0_d;
    e1_q <= e1_d;
  end
endmodule

// File: doc/wb_port_arbiter.md
WB_PORT_ARBITER -- requirements
Module: wb_port_arbiter

Interface
REQ-001 Parameter STARVE_MAX, default 3: consecutive lost cycles that force port B to win (range 1..7).
REQ-002 clk  input  1  sole clock; all state updates on posedge clk.
REQ-003 rst  input  1  reset, synchronous and active-low.
REQ-004 a_en  input  1  port A (single-cycle ALU writeback) write request.
REQ-005 a_addr  input  5  port A destination register.
REQ-006 a_data  input  32  port A write data.
REQ-007 a_stall  output  1  registered; when 1, port A request this cycle is not accepted and upstream SHALL hold it.
REQ-008 b_valid  input  1  port B (long-latency unit) write request.
REQ-009 b_ready  output  1  port B accept; transfer occurs when b_valid & b_ready.
REQ-010 b_addr  input  5  port B destination register.
REQ-011 b_data  input  32  port B write data.
REQ-012 wr_en  output  1  registered write enable to register file D_En.
REQ-013 wr_addr  output  5  registered register file D_Addr.
REQ-014 wr_data  output  32  registered register file D.

Function
REQ-015 Port B transfers SHALL enter a 2-entry FIFO; b_ready SHALL equal (FIFO count < 2) from registered count, so no push occurs while full even if a pop happens that cycle.
REQ-016 Per cycle, winner selection: if a_stall=0 and a_en=1, A wins; else if FIFO non-empty, FIFO head wins and is popped; else no winner.
REQ-017 Winner's addr/data SHALL appear on wr_addr/wr_data with wr_en=1 exactly one cycle after selection; with no winner wr_en=0 and wr_addr/wr_data hold previous values.
REQ-018 A winner with address 0 SHALL be consumed (FIFO entry popped, A accepted) but drive wr_en=0.
REQ-019 Push and pop in the same cycle on a 1-entry FIFO SHALL leave count at 1 with the new entry at head.
REQ-020 Push into empty FIFO SHALL not be eligible to win in the same cycle (minimum B latency: 2 cycles from transfer to wr_en).
REQ-021 Starvation counter (3 bits): increments each cycle FIFO non-empty and A wins; clears when FIFO pops or FIFO empty.
REQ-022 a_stall SHALL be 1 in the cycle after the counter reaches STARVE_MAX, for exactly one cycle; in that cycle FIFO head wins regardless of a_en.
REQ-023 FIFO order SHALL be preserved; no entry SHALL be dropped or duplicated.
REQ-024 No address-coherence check between ports; ordering across ports is the issuing pipeline's responsibility.

Reset
REQ-025 When rst=0 at posedge clk: FIFO empty, starvation counter 0, wr_en=0, wr_addr=0, wr_data=0, a_stall=0; b_ready=1 from first cycle after reset release.
REQ-026 Reset mid-operation SHALL discard buffered entries and any pending write; no wr_en pulse in the cycle after reset is sampled.

Configuration
REQ-027 Macro WB_ARB_STARVE_GUARD_EN defined: starvation counter and a_stall per REQ-021/022 present.
REQ-028 Macro WB_ARB_STARVE_GUARD_EN undefined: counter absent, a_stall tied 0, pure fixed priority A over B (B may starve indefinitely).

Verification
REQ-029 Reset, then B transfer addr=5 data=0xDEADBEEF, a_en=0 -> wr_en=1, wr_addr=5, wr_data=0xDEADBEEF exactly 2 cycles after transfer.
REQ-030 Same cycle A addr=3 data=0x11 with FIFO holding addr=7 data=0x22 -> next cycle writes reg3=0x11, following cycle reg7=0x22.
REQ-031 Two B transfers with a_en=1 continuously -> b_ready=0 after second; third b_valid held until a pop; FIFO order preserved.
REQ-032 Guard enabled, STARVE_MAX=3, FIFO non-empty, a_en=1 continuously -> a_stall=1 on 4th cycle, B entry written next cycle, a_stall=0 after; guard disabled -> B never written while a_en=1.
REQ-033 A addr=0 and B addr=0 requests -> both consumed, wr_en stays 0.
REQ-034 Assert rst=0 with 2 FIFO entries -> wr_en=0 following cycle, b_ready=1 after release, no stale writes emitted.
